// File: rtl/vga_layer_compositor.sv
// VGA raster timing generator with a fixed-priority layer compositor.
// Sync, data-enable and colour outputs are delay-matched to the pixel
// sources, which answer a raster coordinate SRC_LATENCY clocks after it is
// presented on pix_x_o/pix_y_o.
module vga_layer_compositor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int PIX_WIDTH   = 12,
  parameter int COLOR_W     = 8,
  parameter int LAYERS      = 2,
  parameter int SRC_LATENCY = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  output logic [PIX_WIDTH-1:0]          pix_x_o,
  output logic [PIX_WIDTH-1:0]          pix_y_o,
  output logic                          pix_active_o,
  output logic                          frame_start_o,
  output logic                          line_start_o,
  input  logic [LAYERS*3*COLOR_W-1:0]   layer_rgb_i,
  input  logic [LAYERS-1:0]             layer_en_i,
  input  logic [LAYERS-1:0]             layer_mask_i,
  input  logic [3*COLOR_W-1:0]          bg_rgb_i,
  output logic                          vga_hs_o,
  output logic                          vga_vs_o,
  output logic                          vga_de_o,
  output logic [COLOR_W-1:0]            vga_r_o,
  output logic [COLOR_W-1:0]            vga_g_o,
  output logic [COLOR_W-1:0]            vga_b_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW      = 3 * COLOR_W;

  logic [PIX_WIDTH-1:0] h_cnt;
  logic [PIX_WIDTH-1:0] v_cnt;
  logic                 raw_hs;
  logic                 raw_vs;
  logic                 raw_active;
  logic [2:0]           raw_vec;
  logic [2:0]           dly_vec;
  logic [CW-1:0]        sel_rgb;
  logic                 hs_q;
  logic                 vs_q;
  logic                 de_q;
  logic [CW-1:0]        rgb_q;

  // Raster counters: x advances every clock, y advances on each line wrap
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == PIX_WIDTH'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      if (v_cnt == PIX_WIDTH'(V_TOTAL - 1)) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + PIX_WIDTH'(1);
      end
    end else begin
      h_cnt <= h_cnt + PIX_WIDTH'(1);
    end
  end

  // Segment decode of the current count; sync flags are polarity-free here
  assign raw_active = (h_cnt < PIX_WIDTH'(H_ACTIVE)) && (v_cnt < PIX_WIDTH'(V_ACTIVE));
  assign raw_hs     = (h_cnt >= PIX_WIDTH'(H_ACTIVE + H_FP)) &&
                      (h_cnt <  PIX_WIDTH'(H_ACTIVE + H_FP + H_SYNC));
  assign raw_vs     = (v_cnt >= PIX_WIDTH'(V_ACTIVE + V_FP)) &&
                      (v_cnt <  PIX_WIDTH'(V_ACTIVE + V_FP + V_SYNC));
  assign raw_vec    = {raw_hs, raw_vs, raw_active};

  assign pix_x_o       = h_cnt;
  assign pix_y_o       = v_cnt;
  assign pix_active_o  = raw_active;
  assign line_start_o  = (h_cnt == '0);
  assign frame_start_o = (h_cnt == '0) && (v_cnt == '0);

  generate
    if (SRC_LATENCY == 0) begin : g_no_dly
      assign dly_vec = raw_vec;
    end else begin : g_dly
      logic [2:0] stage [SRC_LATENCY];

      // Timing delay line; clears to "no sync, blanked" so no false pulses after reset
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          for (int i = 0; i < SRC_LATENCY; i++) stage[i] <= '0;
        end else begin
          stage[0] <= raw_vec;
          for (int i = 1; i < SRC_LATENCY; i++) stage[i] <= stage[i-1];
        end
      end

      assign dly_vec = stage[SRC_LATENCY-1];
    end
  endgenerate

  // Fixed-priority merge: the highest visible layer wins, else the background
  always_comb begin
    sel_rgb = bg_rgb_i;
    for (int k = 0; k < LAYERS; k++) begin
      if (layer_en_i[k] && layer_mask_i[k]) sel_rgb = layer_rgb_i[k*CW +: CW];
    end
  end

  // Output stage: register colour with the delayed timing, blanking outside the active area
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= dly_vec[2];
      vs_q  <= dly_vec[1];
      de_q  <= dly_vec[0];
      rgb_q <= dly_vec[0] ? sel_rgb : '0;
    end
  end

  assign vga_hs_o = (HS_POL != 0) ? hs_q : ~hs_q;
  assign vga_vs_o = (VS_POL != 0) ? vs_q : ~vs_q;
  assign vga_de_o = de_q;
  assign vga_r_o  = rgb_q[CW-1 -: COLOR_W];
  assign vga_g_o  = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_b_o  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Scoreboard bench for vga_layer_compositor using a reduced raster so that
// several full frames and a mid-frame asynchronous reset fit in a short run.
module tb_vga_layer_compositor;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int HS_POL   = 1;
  localparam int VS_POL   = 0;
  localparam int PIX_W    = 12;
  localparam int COLOR_W  = 8;
  localparam int LAYERS   = 3;
  localparam int LAT      = 3;
  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = HT * VT;
  localparam int CW       = 3 * COLOR_W;

  logic                     clk_i = 1'b0;
  logic                     rst_n_i = 1'b0;
  logic [PIX_W-1:0]         pix_x_o;
  logic [PIX_W-1:0]         pix_y_o;
  logic                     pix_active_o;
  logic                     frame_start_o;
  logic                     line_start_o;
  logic [LAYERS*CW-1:0]     layer_rgb_i = '0;
  logic [LAYERS-1:0]        layer_en_i = '0;
  logic [LAYERS-1:0]        layer_mask_i = '0;
  logic [CW-1:0]            bg_rgb_i = '0;
  logic                     vga_hs_o;
  logic                     vga_vs_o;
  logic                     vga_de_o;
  logic [COLOR_W-1:0]       vga_r_o;
  logic [COLOR_W-1:0]       vga_g_o;
  logic [COLOR_W-1:0]       vga_b_o;

  typedef struct {
    logic           hs;
    logic           vs;
    logic           de;
    logic [CW-1:0]  rgb;
  } out_t;

  typedef struct {
    int   x;
    int   y;
    logic act;
    logic fs;
    logic ls;
  } cnt_t;

  out_t out_q[$];
  cnt_t cnt_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  localparam logic HS_IDLE = (HS_POL != 0) ? 1'b0 : 1'b1;
  localparam logic VS_IDLE = (VS_POL != 0) ? 1'b0 : 1'b1;

  vga_layer_compositor #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .PIX_WIDTH(PIX_W), .COLOR_W(COLOR_W),
    .LAYERS(LAYERS), .SRC_LATENCY(LAT)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .pix_x_o(pix_x_o), .pix_y_o(pix_y_o), .pix_active_o(pix_active_o),
    .frame_start_o(frame_start_o), .line_start_o(line_start_o),
    .layer_rgb_i(layer_rgb_i), .layer_en_i(layer_en_i),
    .layer_mask_i(layer_mask_i), .bg_rgb_i(bg_rgb_i),
    .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o), .vga_de_o(vga_de_o),
    .vga_r_o(vga_r_o), .vga_g_o(vga_g_o), .vga_b_o(vga_b_o)
  );

  // Pixel clock
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
               name, $time, act, act, exp, exp);
    end
  endtask

  // Expected output for raster index idx (negative = before any real pixel)
  function automatic out_t model_out(input int idx, input logic [CW-1:0] lay [LAYERS],
                                     input logic [LAYERS-1:0] en, input logic [LAYERS-1:0] mask,
                                     input logic [CW-1:0] bg);
    out_t o;
    int   x;
    int   y;
    o.hs  = HS_IDLE;
    o.vs  = VS_IDLE;
    o.de  = 1'b0;
    o.rgb = '0;
    if (idx < 0) return o;
    x = idx % HT;
    y = (idx / HT) % VT;
    if (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) o.hs = ~HS_IDLE;
    if (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) o.vs = ~VS_IDLE;
    o.de = (x < H_ACTIVE) && (y < V_ACTIVE);
    if (o.de) begin
      o.rgb = bg;
      for (int k = LAYERS - 1; k >= 0; k--) begin
        if (en[k] && mask[k]) begin
          o.rgb = lay[k];
          break;
        end
      end
    end
    return o;
  endfunction

  // Drive the sources for raster slot n and record what the DUT should show
  task automatic applyStimulus(input int n);
    cnt_t                c;
    logic [CW-1:0]       lay [LAYERS];
    logic [LAYERS-1:0]   en;
    logic [LAYERS-1:0]   mask;
    logic [CW-1:0]       bg;
    int                  src;
    int                  xs;
    int                  ys;
    logic [7:0]          xb;
    logic [7:0]          yb;
    c.x   = n % HT;
    c.y   = (n / HT) % VT;
    c.act = (c.x < H_ACTIVE) && (c.y < V_ACTIVE);
    c.fs  = (c.x == 0) && (c.y == 0);
    c.ls  = (c.x == 0);
    cnt_q.push_back(c);

    src = n - LAT;
    xs  = (src < 0) ? 0 : src % HT;
    ys  = (src < 0) ? 0 : (src / HT) % VT;
    bg  = CW'($urandom);
    if (src >= 0 && !(xs < H_ACTIVE && ys < V_ACTIVE)) begin
      for (int k = 0; k < LAYERS; k++) lay[k] = 24'hFFFFFF;
      en   = '1;
      mask = '1;
    end else begin
      xb     = 8'(xs);
      yb     = 8'(ys);
      lay[0] = {xb, yb, 8'h00};
      for (int k = 1; k < LAYERS; k++) lay[k] = CW'($urandom);
      en   = LAYERS'($urandom);
      mask = ($urandom_range(0, 3) == 0) ? LAYERS'($urandom) : '1;
    end
    for (int k = 0; k < LAYERS; k++) layer_rgb_i[k*CW +: CW] = lay[k];
    layer_en_i   = en;
    layer_mask_i = mask;
    bg_rgb_i     = bg;
    out_q.push_back(model_out(src, lay, en, mask, bg));
  endtask

  function automatic out_t reset_item();
    out_t o;
    o.hs  = HS_IDLE;
    o.vs  = VS_IDLE;
    o.de  = 1'b0;
    o.rgb = '0;
    return o;
  endfunction

  task automatic check_reset_values();
    checkOutput("rst_pix_x", int'(pix_x_o), 0);
    checkOutput("rst_pix_y", int'(pix_y_o), 0);
    checkOutput("rst_active", int'(pix_active_o), 1);
    checkOutput("rst_frame_start", int'(frame_start_o), 1);
    checkOutput("rst_line_start", int'(line_start_o), 1);
    checkOutput("rst_hs", int'(vga_hs_o), int'(HS_IDLE));
    checkOutput("rst_vs", int'(vga_vs_o), int'(VS_IDLE));
    checkOutput("rst_de", int'(vga_de_o), 0);
    checkOutput("rst_rgb", int'({vga_r_o, vga_g_o, vga_b_o}), 0);
  endtask

  // Release reset on the current slot and run num raster slots
  task automatic run_phase(input int num);
    out_q.push_back(reset_item());
    rst_n_i = 1'b1;
    mon_en  = 1'b1;
    for (int n = 0; n < num; n++) begin
      if (n > 0) begin
        @(posedge clk_i);
        #1;
      end
      applyStimulus(n);
    end
  endtask

  // Monitor: compare the DUT against the scoreboard heads once per pixel
  always @(negedge clk_i) begin
    cnt_t c;
    out_t o;
    if (mon_en) begin
      if (cnt_q.size() > 0) begin
        c = cnt_q.pop_front();
        checkOutput("pix_x", int'(pix_x_o), c.x);
        checkOutput("pix_y", int'(pix_y_o), c.y);
        checkOutput("pix_active", int'(pix_active_o), int'(c.act));
        checkOutput("frame_start", int'(frame_start_o), int'(c.fs));
        checkOutput("line_start", int'(line_start_o), int'(c.ls));
      end
      if (out_q.size() > 0) begin
        o = out_q.pop_front();
        checkOutput("vga_hs", int'(vga_hs_o), int'(o.hs));
        checkOutput("vga_vs", int'(vga_vs_o), int'(o.vs));
        checkOutput("vga_de", int'(vga_de_o), int'(o.de));
        checkOutput("vga_r", int'(vga_r_o), int'(o.rgb[23:16]));
        checkOutput("vga_g", int'(vga_g_o), int'(o.rgb[15:8]));
        checkOutput("vga_b", int'(vga_b_o), int'(o.rgb[7:0]));
      end
    end
  end

  // Main sequence: reset, three frames, asynchronous reset mid-line, two more frames
  initial begin
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_values();

    run_phase(3 * FRAME + 4 * HT + 21);
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    mon_en = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_values();
    out_q.delete();
    cnt_q.delete();

    repeat (2) @(posedge clk_i);
    #1;
    check_reset_values();
    run_phase(2 * FRAME + LAT + 4);
    @(negedge clk_i);
    #1;
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_layer_compositor.md
# vga_layer_compositor

Parametrised VGA timing generator and per-pixel layer compositor that replaces the fixed-mode renderer top in the game display path. It generates raster coordinates for the pixel sources (game field, next-piece preview, score overlay), merges up to `LAYERS` source colours by fixed priority over a programmable background, and emits sync, data-enable and RGB outputs. Sync and data-enable are delay-matched to the sources' pipeline latency. It sits between the game-logic draw modules and the VGA/HDMI transmitter pins.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `HS_POL`, 0, hsync active level (0 = active low)
- `VS_POL`, 0, vsync active level
- `PIX_WIDTH`, 12, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- `COLOR_W`, 8, bits per colour channel
- `LAYERS`, 2, number of source layers (1..8)
- `SRC_LATENCY`, 1, clocks from `pix_x_o`/`pix_y_o` to the matching `layer_*_i` values (0..15)

Ports:
- `clk_i` in 1: pixel clock
- `rst_n_i` in 1: asynchronous active-low reset
- `pix_x_o` out PIX_WIDTH: current horizontal count, 0..H_TOTAL-1
- `pix_y_o` out PIX_WIDTH: current vertical count, 0..V_TOTAL-1
- `pix_active_o` out 1: current count lies in the active area
- `frame_start_o` out 1: one-clock pulse when the count is (0,0)
- `line_start_o` out 1: one-clock pulse when `pix_x_o` == 0
- `layer_rgb_i` in LAYERS*3*COLOR_W: per-layer {R,G,B}; layer k occupies slice k
- `layer_en_i` in LAYERS: per-pixel opacity of each layer
- `layer_mask_i` in LAYERS: quasi-static layer enable mask
- `bg_rgb_i` in 3*COLOR_W: background colour
- `vga_hs_o` out 1: horizontal sync
- `vga_vs_o` out 1: vertical sync
- `vga_de_o` out 1: display enable
- `vga_r_o`, `vga_g_o`, `vga_b_o` out COLOR_W each: pixel colour

## Operation
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP. V_TOTAL is defined the same way from the vertical parameters.
- Horizontal segment order: active [0, H_ACTIVE), then front porch, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then back porch. Vertical uses the same order in lines.
- The horizontal counter increments every clock and wraps from H_TOTAL-1 to 0. The vertical counter increments on each horizontal wrap and wraps from V_TOTAL-1 to 0. Both wraps occur on the same clock at the end of a frame.
- `pix_x_o`, `pix_y_o`, `pix_active_o`, `frame_start_o` and `line_start_o` are the registered counter state. All are mutually aligned.
- Raw sync condition: h is in the H sync segment, or v is in the V sync segment (full lines). Outputs are driven at the active level set by `*_POL`.
- Compositing:
  - For k = 0..LAYERS-1, layer k is eligible when `layer_en_i[k] & layer_mask_i[k]`.
  - The highest eligible index wins.
  - If no layer is eligible, `bg_rgb_i` is selected.
- Delay matching:
  - Raw hs, vs and active pass through a shift register of depth SRC_LATENCY.
  - The colour select is registered together with the delayed raw hs, vs and active.
  - When delayed active = 0, RGB outputs are forced to 0.
- `layer_mask_i` and `bg_rgb_i` are sampled on the same clock as `layer_*_i`. No shadowing is applied, so a change mid-frame takes effect on the next pixel.

## Timing
- Output latency: `vga_*_o` for count (x,y) appears SRC_LATENCY+1 clocks after `pix_x_o`/`pix_y_o` = (x,y).
- With SRC_LATENCY = 0, the layer inputs are used combinationally in the cycle the count is presented.
- Reset (asynchronous assert, synchronous release):
  - Counters and the delay line go to 0.
  - `vga_hs_o` = ~HS_POL and `vga_vs_o` = ~VS_POL (inactive levels).
  - `vga_de_o` = 0, RGB outputs = 0.
  - `pix_active_o` = 1, `frame_start_o` = 1 and `line_start_o` = 1, because the count is (0,0).
  - The delay line resets to the inactive/blank state, so no spurious sync pulse is generated during the first SRC_LATENCY+1 clocks.
- Reset mid-frame: outputs return to their reset values immediately. Timing restarts at (0,0) on the first clock after release. No partial-frame recovery is performed.
- Defaults:
  - Line = 800 clocks, frame = 525 lines = 420000 clocks.
  - hs active for 96 clocks per line, vs active for 2 full lines (1600 clocks) per frame.
  - de high for 640 clocks on each of 480 lines.

## Test plan
- **Reset and defaults:** hold reset, release, then run 2 frames.
  - During reset: hs = vs = 1, de = 0, RGB = 0.
  - frame_start pulses every 420000 clocks.
  - hs goes low at delayed x = 656 for 96 clocks.
  - vs goes low for lines 490–491.
- **Latency alignment, SRC_LATENCY = 3:** a model source drives `layer_rgb_i` = {x[7:0], y[7:0], 0} with 3-cycle lag.
  - Output pixel at de rising edge = (0,0,0).
  - The 640th de pixel has R = 0x7F (639 mod 256).
  - de and hs edges sit exactly 4 clocks after the matching counter values.
- **Priority:** LAYERS = 3, all masked in, en = 3'b011 → layer 1 colour; en = 3'b101 → layer 2; en = 0 → bg_rgb_i. Mask = 3'b001 with en = 3'b111 → layer 0.
- **Blanking:** drive all layers opaque 0xFFFFFF during porches and sync → RGB = 0 and de = 0 for every non-active pixel.
- **Non-default mode, 800x600 timing, positive polarity:** set H_FP 40, H_SYNC 128, H_BP 88, V_FP 1, V_SYNC 4, V_BP 23, HS_POL = VS_POL = 1.
  - Line = 1056 clocks, frame = 628 lines.
  - hs active high for 128 clocks.
- **Asynchronous reset mid-line:** assert rst_n_i low at x = 700, y = 300, asynchronous to the clock.
  - Outputs reach reset values without waiting for a clock edge.
  - After release, `pix_x_o`/`pix_y_o` = (0,0) and the next frame_start occurs 420000 clocks later.
